// File: rtl/axi_read_master.sv
// -----------------------------------------------------------------------------
// axi_read_master
// AXI4 read-channel initiator (AR/R). Accepts one single-word or INCR burst
// request at a time from a client, issues it on AR, forwards R beats to the
// client with per-beat valid/ready, and flags a burst error on the last beat.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   req_valid/req_ready          client request handshake
//   req_addr, req_len            start byte address, beats-1
//   rsp_valid/rsp_ready          client beat handshake
//   rsp_data, rsp_last, rsp_err  beat data, master-counted last, error status
//   AR*_M                        AXI read address channel (master side)
//   R*_M                         AXI read data channel (master side)
// -----------------------------------------------------------------------------
module axi_read_master #(
    parameter logic [3:0] MASTER_ID = 4'd0,
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // client request
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    output logic              req_ready,
    // client response
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    input  logic              rsp_ready,
    // AXI read address channel
    output logic [3:0]        ARID_M,
    output logic [ADDR_W-1:0] ARADDR_M,
    output logic [3:0]        ARLEN_M,
    output logic [2:0]        ARSIZE_M,
    output logic [1:0]        ARBURST_M,
    output logic              ARVALID_M,
    input  logic              ARREADY_M,
    // AXI read data channel
    input  logic [3:0]        RID_M,
    input  logic [DATA_W-1:0] RDATA_M,
    input  logic [1:0]        RRESP_M,
    input  logic              RLAST_M,
    input  logic              RVALID_M,
    output logic              RREADY_M
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                beat_last_s;
    logic                beat_err_s;

    // Byte-lane bits of the request address are never used: transfers are
    // always word aligned.
    logic [1:0]          unused_addr_s;
    assign unused_addr_s = req_addr[1:0];

    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = len_q;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;

    // The master-side beat count is authoritative for the last beat; the
    // slave's RLAST is only compared against it.
    assign beat_last_s = (cnt_q == len_q);
    assign beat_err_s  = (RRESP_M != 2'b00) | (RID_M != MASTER_ID) | (RLAST_M != beat_last_s);

    // State and burst context registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            len_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and channel outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_ready = 1'b0;
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = {DATA_W{1'b0}};
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Held low while reset is applied so no request is taken.
                req_ready = ~ARESET;
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    len_d   = req_len;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                ARVALID_M = 1'b1;
                if (ARREADY_M) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                // R channel is a direct pass-through to the client so
                // backpressure needs no buffering.
                RREADY_M  = rsp_ready;
                rsp_valid = RVALID_M;
                rsp_data  = RDATA_M;
                rsp_last  = beat_last_s;
                rsp_err   = err_q | beat_err_s;
                if (RVALID_M && rsp_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    err_d = err_q | beat_err_s;
                    if (beat_last_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_read_master.sv
module tb_axi_read_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        rsp_ready;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;

    int n_checks = 0;
    int n_errors = 0;

    axi_read_master dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .ARID_M    (ARID_M),
        .ARADDR_M  (ARADDR_M),
        .ARLEN_M   (ARLEN_M),
        .ARSIZE_M  (ARSIZE_M),
        .ARBURST_M (ARBURST_M),
        .ARVALID_M (ARVALID_M),
        .ARREADY_M (ARREADY_M),
        .RID_M     (RID_M),
        .RDATA_M   (RDATA_M),
        .RRESP_M   (RRESP_M),
        .RLAST_M   (RLAST_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_arvalid"},   32'(ARVALID_M), 32'd0);
        chk({tag, "_rready"},    32'(RREADY_M),  32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // err_kind: 0 clean, 1 bad RRESP on beat 1, 2 RID=5 on a random beat,
    // 3 RLAST on beat 0, 4 random faults. bp_mode: 0 always ready,
    // 1 pattern 1,0,0 repeating, 2 random. abort_at >= 0 stops after that
    // many accepted beats (caller then applies reset).
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                             input int ar_delay, input int err_kind,
                             input int bp_mode, input int abort_at);
        logic [31:0] dat  [16];
        logic [1:0]  rsp  [16];
        logic [3:0]  rid  [16];
        logic        lst  [16];
        logic        run_err;
        int          w;
        int          i;
        int          cyc;
        int          n;

        n = int'(len) + 1;
        for (int k = 0; k < 16; k++) begin
            dat[k] = $urandom;
            rsp[k] = 2'b00;
            rid[k] = 4'd0;
            lst[k] = (k == n - 1);
        end
        case (err_kind)
            1: rsp[(n > 1) ? 1 : 0] = 2'b10;
            2: rid[$urandom_range(0, n - 1)] = 4'd5;
            3: lst[0] = ~lst[0];
            4: begin
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 7) == 0) rsp[k] = 2'($urandom_range(1, 3));
                    if ($urandom_range(0, 9) == 0) rid[k] = 4'($urandom_range(1, 15));
                    if ($urandom_range(0, 9) == 0) lst[k] = ~lst[k];
                end
            end
            default: ;
        endcase

        // request phase
        @(negedge ACLK);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        #1 chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge ACLK);
        @(negedge ACLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 4'($urandom);

        // address phase: ARVALID one cycle after acceptance, held stable
        w = 0;
        while (1) begin
            ARREADY_M = (w >= ar_delay);
            #1;
            chk("arvalid",   32'(ARVALID_M), 32'd1);
            chk("araddr",    ARADDR_M, addr & 32'hFFFF_FFFC);
            chk("arlen",     32'(ARLEN_M), 32'(len));
            chk("arid",      32'(ARID_M), 32'd0);
            chk("arsize",    32'(ARSIZE_M), 32'd2);
            chk("arburst",   32'(ARBURST_M), 32'd1);
            chk("req_busy",  32'(req_ready), 32'd0);
            @(posedge ACLK);
            @(negedge ACLK);
            w++;
            if (w > ar_delay) break;
        end
        ARREADY_M = 1'b0;

        // data phase
        i       = 0;
        cyc     = 0;
        run_err = 1'b0;
        while (i < n) begin
            if (abort_at >= 0 && i == abort_at) break;
            if (cyc > 400) begin
                chk("data_timeout", 32'd1, 32'd0);
                break;
            end
            RVALID_M = ($urandom_range(0, 3) != 0);
            case (bp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (cyc % 3 == 0);
                default: rsp_ready = 1'($urandom);
            endcase
            if (RVALID_M) begin
                RDATA_M = dat[i];
                RRESP_M = rsp[i];
                RID_M   = rid[i];
                RLAST_M = lst[i];
            end else begin
                RDATA_M = $urandom;
                RRESP_M = 2'b00;
                RID_M   = 4'd0;
                RLAST_M = 1'b0;
            end
            #1;
            chk("rready_mirror", 32'(RREADY_M), 32'(rsp_ready));
            chk("rsp_valid",     32'(rsp_valid), 32'(RVALID_M));
            if (RVALID_M && rsp_ready) begin
                run_err = run_err | (rsp[i] != 2'b00) | (rid[i] != 4'd0) | (lst[i] != (i == n - 1));
                chk("rsp_data", rsp_data, dat[i]);
                chk("rsp_last", 32'(rsp_last), 32'(i == n - 1));
                chk("rsp_err",  32'(rsp_err), 32'(run_err));
                i++;
            end
            @(posedge ACLK);
            @(negedge ACLK);
            cyc++;
        end
        RVALID_M  = 1'b0;
        rsp_ready = 1'b0;
        if (abort_at < 0) begin
            #1 idle_outputs("post_burst");
        end
    endtask

    initial begin
        ARESET    = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_len   = 4'd0;
        rsp_ready = 1'b0;
        ARREADY_M = 1'b0;
        RID_M     = 4'd0;
        RDATA_M   = 32'd0;
        RRESP_M   = 2'b00;
        RLAST_M   = 1'b0;
        RVALID_M  = 1'b0;

        // reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #1 chk("rst_req_ready_low", 32'(req_ready), 32'd0);
        chk("rst_araddr", ARADDR_M, 32'd0);
        chk("rst_arlen",  32'(ARLEN_M), 32'd0);
        ARESET = 1'b0;
        #1 idle_outputs("reset");

        // directed: single beat
        run_burst(32'h0000_0104, 4'd0, 0, 0, 0, -1);
        // directed: 4-beat burst with ARREADY delayed 3 cycles
        run_burst(32'h0000_2000, 4'd3, 3, 0, 0, -1);
        // directed: backpressure pattern
        run_burst(32'h0000_4000, 4'd3, 0, 0, 1, -1);
        // directed error cases
        run_burst(32'h0000_5000, 4'd1, 1, 1, 0, -1);
        run_burst(32'h0000_6000, 4'd0, 0, 2, 0, -1);
        run_burst(32'h0000_7000, 4'd1, 0, 3, 2, -1);

        // reset mid-burst after two beats of four, slave still presenting data
        run_burst(32'h0000_8000, 4'd3, 0, 0, 0, 2);
        @(negedge ACLK);
        ARESET   = 1'b1;
        RVALID_M = 1'b1;
        RDATA_M  = 32'hBAD0_BAD0;
        RLAST_M  = 1'b0;
        rsp_ready = 1'b1;
        #1 chk("midrst_req_ready_low", 32'(req_ready), 32'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 idle_outputs("midrst");
        chk("midrst_araddr",   ARADDR_M, 32'd0);
        chk("midrst_arlen",    32'(ARLEN_M), 32'd0);
        chk("midrst_rsp_last", 32'(rsp_last), 32'd0);
        chk("midrst_rsp_err",  32'(rsp_err), 32'd0);
        RVALID_M  = 1'b0;
        rsp_ready = 1'b0;
        run_burst(32'h0000_3000, 4'd3, 1, 0, 2, -1);

        // stray RVALID while idle
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            RVALID_M  = 1'b1;
            RLAST_M   = 1'b1;
            RDATA_M   = $urandom;
            rsp_ready = 1'b1;
            #1 idle_outputs("stray");
        end
        RVALID_M  = 1'b0;
        rsp_ready = 1'b0;
        RLAST_M   = 1'b0;
        // state unchanged: a normal burst still works
        run_burst(32'h0000_9008, 4'd2, 0, 0, 0, -1);

        // randomized bursts
        for (int t = 0; t < 30; t++) begin
            run_burst($urandom, 4'($urandom), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
